input_unit: RTL and testbench

Per-port receive stage of the router: it accepts flits from a neighbouring router's output stage over a four-phase req/ack link and buffers them in a small FIFO. It computes an XY route for each head flit and holds a one-hot switch request toward the output units for the whole packet (wormhole), popping one flit per switch ack. One instance sits on each of the NUM_OF_PORTS inputs, directly downstream of the link driven by the upstream router's output stage.

---
 rtl/router_pkg.sv | 52 +++++
 rtl/flit_fifo.sv | 55 +++++
 rtl/input_unit.sv | 103 ++++++++++
 tb/tb_input_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: port indices, flit format and the XY routing helper.
package router_pkg;

    localparam int NUM_OF_PORTS = 5;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    localparam int COORD_W   = 4;
    localparam int PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        HEAD      = 2'd0,
        BODY      = 2'd1,
        TAIL      = 2'd2,
        HEAD_TAIL = 2'd3
    } FLIT_TYPE_t;

    typedef struct packed {
        FLIT_TYPE_t           flit_type;
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef struct packed {
        flit_t flit;
    } router_pipeline_bus_t;

    localparam int FLIT_W = $bits(flit_t);

    // Dimension-ordered route: resolve X first, then Y, else deliver locally.
    function automatic logic [NUM_OF_PORTS-1:0] xy_route(
        input logic [COORD_W-1:0] dest_x,
        input logic [COORD_W-1:0] dest_y,
        input logic [COORD_W-1:0] here_x,
        input logic [COORD_W-1:0] here_y
    );
        logic [NUM_OF_PORTS-1:0] r;
        r = '0;
        if (dest_x > here_x)      r[EAST]  = 1'b1;
        else if (dest_x < here_x) r[WEST]  = 1'b1;
        else if (dest_y > here_y) r[NORTH] = 1'b1;
        else if (dest_y < here_y) r[SOUTH] = 1'b1;
        else                      r[LOCAL] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Small circular flit buffer; head is read combinationally, no write-to-read bypass.
module flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged before any same-edge pop, so a pop never makes room for that edge's push.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage: entries are only observed once counted valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally (power-of-two depth); count tracks pushes minus pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_unit.sv
// Router input port: four-phase link capture into a FIFO, XY route per packet, wormhole switch request.
module input_unit
    import router_pkg::*;
#(
    parameter int                 BUF_DEPTH = 4,
    parameter logic [COORD_W-1:0] LOCAL_X   = '0,
    parameter logic [COORD_W-1:0] LOCAL_Y   = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_upstream_req,
    input  router_pipeline_bus_t               i_u2i,
    output logic                               o_upstream_ack,
    output logic [NUM_OF_PORTS-1:0]            o_switch_request,
    input  logic                               i_switch_ack,
    output router_pipeline_bus_t               o_i2s,
    output logic [$clog2(BUF_DEPTH+1)-1:0]     o_occupancy,
    output logic                               o_err
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [NUM_OF_PORTS-1:0] route_q;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic [FLIT_W-1:0]       head_bits;
    flit_t                   head;
    logic                    head_is_start;
    logic                    head_is_end;

    assign head          = flit_t'(head_bits);
    assign head_is_start = (head.flit_type == HEAD) || (head.flit_type == HEAD_TAIL);
    assign head_is_end   = (head.flit_type == TAIL) || (head.flit_type == HEAD_TAIL);

    // A new flit is taken only on the rising half of a handshake, and only if there is room.
    assign push = i_upstream_req && !o_upstream_ack && !full;

    // Orphans are discarded while idle; inside a packet the switch ack drives the pop.
    assign pop = !empty && ((state == IDLE && !head_is_start) ||
                            (state == ACTIVE && i_switch_ack));

    flit_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (i_u2i.flit),
        .rdata (head_bits),
        .full  (full),
        .empty (empty),
        .count (o_occupancy)
    );

    // Drive zero when empty so stale storage never leaks to the switch.
    assign o_i2s.flit = empty ? '0 : head;

    // Request is dropped while the buffer is drained mid-packet; the route itself is kept.
    assign o_switch_request = (state == ACTIVE && !empty) ? route_q : '0;

    // Four-phase ack: rises on capture, falls on the first edge that sees req low.
    always_ff @(posedge clk) begin
        if (reset)                o_upstream_ack <= 1'b0;
        else if (push)            o_upstream_ack <= 1'b1;
        else if (!i_upstream_req) o_upstream_ack <= 1'b0;
    end

    // Packet FSM: route on head, hold until the flit closing the packet is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            route_q <= '0;
            o_err   <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (head_is_start) begin
                            route_q <= xy_route(head.dest_x, head.dest_y, LOCAL_X, LOCAL_Y);
                            state   <= ACTIVE;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (i_switch_ack && !empty && head_is_end) begin
                        state   <= IDLE;
                        route_q <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_input_unit.sv
// Self-checking bench for input_unit: queue-based reference model plus directed and random traffic.
module tb_input_unit;
    import router_pkg::*;

    localparam int                 BUF_DEPTH = 4;
    localparam int                 OCC_W     = $clog2(BUF_DEPTH+1);
    localparam logic [COORD_W-1:0] LX        = 4'd2;
    localparam logic [COORD_W-1:0] LY        = 4'd2;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    req = 1'b0;
    logic                    swack = 1'b0;
    router_pipeline_bus_t    u2i = '0;
    router_pipeline_bus_t    i2s;
    logic                    ack;
    logic                    err;
    logic [NUM_OF_PORTS-1:0] sreq;
    logic [OCC_W-1:0]        occ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_unit #(
        .BUF_DEPTH (BUF_DEPTH),
        .LOCAL_X   (LX),
        .LOCAL_Y   (LY)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_upstream_req   (req),
        .i_u2i            (u2i),
        .o_upstream_ack   (ack),
        .o_switch_request (sreq),
        .i_switch_ack     (swack),
        .o_i2s            (i2s),
        .o_occupancy      (occ),
        .o_err            (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    flit_t                   mq[$];
    bit                      m_ack, m_busy, m_err, m_valid;
    logic [NUM_OF_PORTS-1:0] m_route;

    function automatic logic [NUM_OF_PORTS-1:0] ref_route(input flit_t f);
        logic [NUM_OF_PORTS-1:0] r;
        int port;
        if (f.dest_x > LX)      port = EAST;
        else if (f.dest_x < LX) port = WEST;
        else if (f.dest_y > LY) port = NORTH;
        else if (f.dest_y < LY) port = SOUTH;
        else                    port = LOCAL;
        r = '0;
        r[port] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        bit    do_push;
        flit_t h;
        if (reset) begin
            mq.delete();
            m_ack = 0; m_busy = 0; m_err = 0; m_route = '0; m_valid = 1;
        end else begin
            do_push = req && !m_ack && (mq.size() < BUF_DEPTH);
            m_err = 0;
            if (mq.size() > 0) begin
                h = mq[0];
                if (!m_busy) begin
                    if (h.flit_type == HEAD || h.flit_type == HEAD_TAIL) begin
                        m_busy = 1;
                        m_route = ref_route(h);
                    end else begin
                        void'(mq.pop_front());
                        m_err = 1;
                    end
                end else if (swack) begin
                    void'(mq.pop_front());
                    if (h.flit_type == TAIL || h.flit_type == HEAD_TAIL) begin
                        m_busy = 0;
                        m_route = '0;
                    end
                end
            end
            if (do_push) mq.push_back(u2i.flit);
            if (do_push) m_ack = 1;
            else if (!req) m_ack = 0;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [NUM_OF_PORTS-1:0] er;
        flit_t                   ef;
        if (m_valid) begin
            er = (m_busy && mq.size() != 0) ? m_route : '0;
            ef = (mq.size() != 0) ? mq[0] : '0;
            chk("ack", ack, m_ack);
            chk("switch_request", sreq, er);
            chk("occupancy", occ, mq.size());
            chk("err", err, m_err);
            chk("i2s", i2s.flit, ef);
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic flit_t mk(input FLIT_TYPE_t t, input int x, input int y, input int p);
        flit_t f;
        f.flit_type = t;
        f.dest_x    = COORD_W'(x);
        f.dest_y    = COORD_W'(y);
        f.payload   = PAYLOAD_W'(p);
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_flit(input flit_t f);
        int n;
        u2i.flit = f; req = 1'b1; n = 0;
        do begin step(); n++; end while (!ack && n < 50);
        if (!ack) timeout("ack_rise");
        req = 1'b0; n = 0;
        do begin step(); n++; end while (ack && n < 50);
        if (ack) timeout("ack_fall");
    endtask

    task automatic drain();
        int n;
        swack = 1'b1; n = 0;
        while (occ != 0 && n < 50) begin step(); n++; end
        if (occ != 0) timeout("drain");
        swack = 1'b0;
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int pct;
        // Pin the model's routing rule to hand-derived values.
        chk("model_route_east",  ref_route(mk(HEAD, 3, 2, 0)), 5'b00100);
        chk("model_route_south", ref_route(mk(HEAD, 2, 1, 0)), 5'b01000);
        chk("model_route_local", ref_route(mk(HEAD, 2, 2, 0)), 5'b00001);

        // Reset state
        repeat (3) step();
        chk("rst_ack", ack, 0); chk("rst_req", sreq, 0); chk("rst_occ", occ, 0);
        chk("rst_err", err, 0); chk("rst_i2s", i2s, 0);
        reset = 1'b0;

        // Single HEAD_TAIL eastwards
        u2i.flit = mk(HEAD_TAIL, 3, 2, 16'h1111); req = 1'b1;
        step();
        chk("ht_occ", occ, 1); chk("ht_ack", ack, 1); chk("ht_req_early", sreq, 0);
        req = 1'b0;
        step();
        chk("ht_req", sreq, 5'b00100); chk("ht_ack_fall", ack, 0);
        swack = 1'b1;
        step();
        chk("ht_pop_occ", occ, 0); chk("ht_pop_req", sreq, 0);
        swack = 1'b0;
        step();
        chk("ht_idle_req", sreq, 0);

        // 4-flit packet southwards with switch ack withheld, then a stalled 5th
        send_flit(mk(HEAD, 2, 1, 16'hA000));
        send_flit(mk(BODY, 2, 1, 16'hA001));
        send_flit(mk(BODY, 2, 1, 16'hA002));
        send_flit(mk(TAIL, 2, 1, 16'hA003));
        u2i.flit = mk(HEAD_TAIL, 2, 2, 16'hA004); req = 1'b1;
        repeat (3) step();
        chk("stall_ack", ack, 0); chk("stall_occ", occ, 4); chk("stall_req", sreq, 5'b01000);
        swack = 1'b1;
        step();
        chk("stall_pop_occ", occ, 3); chk("stall_pop_ack", ack, 0); chk("stall_pop_req", sreq, 5'b01000);
        begin
            int n = 0;
            while (!ack && n < 20) begin step(); n++; end
            if (!ack) timeout("stall_release");
        end
        req = 1'b0;
        drain();

        // Req held high for 10 cycles: one flit only
        u2i.flit = mk(HEAD_TAIL, 0, 2, 16'hB0B0); req = 1'b1;
        repeat (10) step();
        chk("held_ack", ack, 1); chk("held_occ", occ, 1); chk("held_req", sreq, 5'b10000);
        req = 1'b0;
        step();
        chk("held_ack_fall", ack, 0); chk("held_occ_after", occ, 1);
        drain();

        // Orphan BODY
        u2i.flit = mk(BODY, 3, 3, 16'hDEAD); req = 1'b1;
        step();
        chk("orph_occ", occ, 1); chk("orph_err0", err, 0);
        req = 1'b0;
        step();
        chk("orph_err", err, 1); chk("orph_occ_after", occ, 0); chk("orph_req", sreq, 0);
        step();
        chk("orph_err_clear", err, 0);

        // Push and pop on the same edge, then a 20-flit stream across pointer wrap
        send_flit(mk(HEAD, 2, 3, 16'hC000));
        send_flit(mk(BODY, 2, 3, 16'hC001));
        u2i.flit = mk(BODY, 2, 3, 16'hC002); req = 1'b1; swack = 1'b1;
        step();
        chk("pushpop_occ", occ, 2); chk("pushpop_req", sreq, 5'b00010);
        req = 1'b0; swack = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            swack = (i % 3 != 0);
            send_flit(mk((i == 19) ? TAIL : BODY, 2, 3, 16'hC100 + i));
        end
        drain();

        // Reset with a partial packet buffered
        send_flit(mk(HEAD, 4, 2, 16'hE000));
        send_flit(mk(BODY, 4, 2, 16'hE001));
        send_flit(mk(BODY, 4, 2, 16'hE002));
        chk("prerst_req", sreq, 5'b00100); chk("prerst_occ", occ, 3);
        reset = 1'b1;
        step();
        chk("midrst_ack", ack, 0); chk("midrst_req", sreq, 0); chk("midrst_occ", occ, 0);
        chk("midrst_err", err, 0); chk("midrst_i2s", i2s, 0);
        reset = 1'b0;
        step();

        // Random traffic against the model
        pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) pct = $urandom_range(10, 95);
            swack = ($urandom_range(0, 99) < pct);
            if (req && ack) req = 1'b0;
            else if (!req && !ack && $urandom_range(0, 2) != 0) begin
                u2i.flit = mk(FLIT_TYPE_t'($urandom_range(0, 3)), $urandom_range(0, 4),
                              $urandom_range(0, 4), $urandom_range(0, 65535));
                req = 1'b1;
            end
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                req = 1'b0;
            end else begin
                reset = 1'b0;
            end
            step();
        end
        reset = 1'b0; req = 1'b0; swack = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
